branch_predict_table: RTL and testbench
=======================================

# branch_predict_table

Direct-mapped branch history/target table for the fetch stage. Each cycle it is read with the fetch PC and returns a taken/not-taken prediction, a predicted next PC, and the 2-bit counter state. It is written one cycle at a time from the resolve (EX) stage. The counter state read at fetch travels down the pipeline and comes back as `ex_state_old`, so the counter update uses the same 2-bit saturating encoding as the rest of the predictor: NTS=00, NTW=01, TW=10, TS=11.

## Interface
Parameters:
- `INDEX_W`, default 6: table has 2^INDEX_W entries.
- `PC_W`, default 32: PC width.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_pc` in PC_W: fetch PC for lookup.
- `pred_hit` out 1: entry is valid and its tag matches.
- `pred_taken` out 1: predicted taken.
- `pred_target` out PC_W: predicted next PC.
- `pred_state` out 2: counter state to carry down the pipeline.
- `ex_valid` in 1: resolve-stage instruction is valid.
- `ex_is_branch` in 1: resolve-stage instruction is a conditional branch.
- `ex_pc` in PC_W: PC of the resolved branch.
- `ex_taken` in 1: actual outcome.
- `ex_target` in PC_W: actual taken target.
- `ex_state_old` in 2: `pred_state` captured when this branch was fetched.

## Operation
Address split:
- index = pc[INDEX_W+1:2]
- tag = pc[PC_W-1:INDEX_W+2]

Each entry holds: valid, tag, 2-bit counter, target.

Lookup (combinational, same cycle as `if_pc`):
- hit = valid & (tag == if_pc tag).
- `pred_state` = hit ? counter : NTS.
- `pred_taken` = hit & pred_state[1].
- `pred_target` = pred_taken ? stored target : if_pc + 4.

Counter next-state from `ex_state_old` and outcome x = `ex_taken`:
- NTS: x → NTW, !x → NTS.
- NTW: x → TS, !x → NTS.
- TW: x → TS, !x → NTS.
- TS: x → TS, !x → TW.

Update occurs when `ex_valid & ex_is_branch & !rst`:
- Tag matches and valid: counter ← next-state. If taken, target ← `ex_target`.
- Miss and taken: allocate. valid ← 1, tag ← ex tag, target ← `ex_target`, counter ← next-state (NTW when `ex_state_old`=NTS). Any existing entry is replaced.
- Miss and not taken: no write.

Bypass rule:
- When an update and a lookup hit the same index in the same cycle, the lookup sees the post-update entry (valid, tag, counter, target). Fetch must never read a value that is one cycle stale.

Reset:
- On a rising edge with `rst`=1, every entry gets valid=0, counter=NTS, target=0.
- While `rst`=1, outputs are forced: `pred_hit`=0, `pred_taken`=0, `pred_state`=NTS, `pred_target`=if_pc+4.
- Updates presented during reset are dropped.

## Timing
- Lookup latency: 0 cycles (combinational from `if_pc` and table state).
- Update is visible to an ordinary lookup from the cycle after the write edge, and in the same cycle through the bypass.
- Reset takes effect in 1 cycle. The first cycle after `rst` falls, every lookup misses.
- Wrap-around: counters saturate at TS and NTS and never wrap. `if_pc`+4 wraps modulo 2^PC_W.
- Aliasing: two PCs with the same index and different tags evict each other on a taken miss. This is intended.
- Reset mid-stream: any in-flight `ex_state_old` arriving after reset is still applied as a normal update against the cleared table, so it behaves as a miss.

## Structure
- Shared package `bp_pkg`:
  - state encodings NTS, NTW, TW, TS;
  - `bp_state_t` typedef;
  - default INDEX_W;
  - index and tag width constants.
- Sub-module `bp_counter_next`: purely combinational, (state_old, x) → state. It is instantiated once for the update path and is reusable elsewhere.
- Table storage is a flop array, not SRAM, because it needs a one-cycle full clear and an asynchronous read.

## Test plan
- After reset, lookup 0x0000_1000 → pred_hit=0, pred_taken=0, pred_state=00, pred_target=0x0000_1004.
- Update pc=0x1000, taken, target=0x2000, state_old=00. Next-cycle lookup of 0x1000 → hit=1, state=01, taken=0, target=0x1004. A second taken update with state_old=01 → state=11, taken=1, target=0x2000.
- Saturation: with the entry at TS, a taken update stays at 11. A not-taken update gives 10. A further not-taken with state_old=10 gives 00.
- Alias: entry for 0x1000 is valid. Update 0x1100 (same index when INDEX_W=6), taken → 0x1000 now misses and 0x1100 hits. Repeat with a not-taken miss → no change.
- Bypass: in the same cycle, update 0x1000 taken (state_old=01) and look up 0x1000 → lookup shows state=11, taken=1 that cycle.
- Reset mid-operation: fill 4 entries, assert `rst` for one cycle together with an update → all lookups miss afterwards and the concurrent update is not written.

Source files
------------

// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor: the 2-bit saturating counter
// encoding, the default table geometry and the derived index/tag widths.
// No ports; imported by bp_counter_next and branch_predict_table.
// -----------------------------------------------------------------------------
package bp_pkg;

  // 2-bit saturating counter: MSB is the taken prediction.
  typedef enum logic [1:0] {
    NTS = 2'b00,  // strongly not taken
    NTW = 2'b01,  // weakly not taken
    TW  = 2'b10,  // weakly taken
    TS  = 2'b11   // strongly taken
  } bp_state_t;

  localparam int BP_INDEX_W = 6;
  localparam int BP_PC_W    = 32;

  // Word-aligned PCs: bits [1:0] carry no information.
  localparam int BP_IDX_LSB = 2;
  localparam int BP_DEPTH   = 1 << BP_INDEX_W;
  localparam int BP_TAG_W   = BP_PC_W - BP_INDEX_W - BP_IDX_LSB;

  function automatic int bp_tag_width(input int pc_w, input int index_w);
    return pc_w - index_w - BP_IDX_LSB;
  endfunction

endpackage

// File: rtl/bp_counter_next.sv
// -----------------------------------------------------------------------------
// bp_counter_next
// Combinational next-state for the 2-bit saturating branch counter.
// Ports:
//   state_old_i : counter value captured at fetch
//   x_i         : resolved outcome (1 = taken)
//   state_o     : updated counter value
// A taken outcome from weakly-not-taken jumps straight to strongly taken, and
// a not-taken outcome from either weak state drops to strongly not taken.
// -----------------------------------------------------------------------------
module bp_counter_next
  import bp_pkg::*;
(
  input  bp_state_t state_old_i,
  input  logic      x_i,
  output bp_state_t state_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives state_o (no latch).
    state_o = NTS;
    case (state_old_i)
      NTS: state_o = x_i ? NTW : NTS;
      NTW: state_o = x_i ? TS  : NTS;
      TW:  state_o = x_i ? TS  : NTS;
      TS:  state_o = x_i ? TS  : TW;
      default: state_o = NTS;
    endcase
  end

endmodule

// File: rtl/branch_predict_table.sv
// -----------------------------------------------------------------------------
// branch_predict_table
// Direct-mapped branch history/target table. Read combinationally with the
// fetch PC, written from the resolve stage one branch per cycle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   if_pc             : fetch PC to look up
//   pred_hit          : entry valid and tag matches
//   pred_taken        : predicted taken
//   pred_target       : predicted next PC (stored target or if_pc+4)
//   pred_state        : counter state carried down the pipeline
//   ex_valid          : resolve-stage instruction valid
//   ex_is_branch      : resolve-stage instruction is a conditional branch
//   ex_pc             : PC of the resolved branch
//   ex_taken          : actual outcome
//   ex_target         : actual taken target
//   ex_state_old      : pred_state captured when the branch was fetched
// -----------------------------------------------------------------------------
module branch_predict_table
  import bp_pkg::*;
#(
  parameter int INDEX_W = BP_INDEX_W,
  parameter int PC_W    = BP_PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  output logic [1:0]      pred_state,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic [1:0]      ex_state_old
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam int TAG_W = bp_tag_width(PC_W, INDEX_W);
  localparam int IDX_H = INDEX_W + BP_IDX_LSB - 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    bp_state_t        ctr;
    logic [PC_W-1:0]  target;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, ctr: NTS, target: '0};

  entry_t table_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Address split
  // ---------------------------------------------------------------------------
  logic [INDEX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]   if_tag, ex_tag;

  assign if_idx = if_pc[IDX_H:BP_IDX_LSB];
  assign if_tag = if_pc[PC_W-1:IDX_H+1];
  assign ex_idx = ex_pc[IDX_H:BP_IDX_LSB];
  assign ex_tag = ex_pc[PC_W-1:IDX_H+1];

  // The byte-offset bits never select anything in a word-aligned table.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{if_pc[BP_IDX_LSB-1:0], ex_pc[BP_IDX_LSB-1:0]};

  // ---------------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------------
  entry_t    ex_entry;
  logic      ex_hit;
  logic      wr_en;
  bp_state_t ctr_next;
  entry_t    wr_entry_d;

  bp_counter_next u_counter_next (
    .state_old_i (bp_state_t'(ex_state_old)),
    .x_i         (ex_taken),
    .state_o     (ctr_next)
  );

  assign ex_entry = table_q[ex_idx];
  assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);

  // Hits always update; misses only allocate when taken. Reset drops updates.
  assign wr_en = ex_valid && ex_is_branch && !rst && (ex_hit || ex_taken);

  // One record covers both cases: on an allocate ex_taken is 1, so the target
  // is always replaced; on a not-taken hit the stored target is kept.
  always_comb begin
    wr_entry_d        = ex_entry;
    wr_entry_d.valid  = 1'b1;
    wr_entry_d.tag    = ex_tag;
    wr_entry_d.ctr    = ctr_next;
    if (ex_taken) begin
      wr_entry_d.target = ex_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole array is cleared in one cycle; this is why the table
      // is built from flops rather than an SRAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= ENTRY_RESET;
      end
    end else if (wr_en) begin
      // NOTE: non-blocking so every reader sees pre-edge table contents.
      table_q[ex_idx] <= wr_entry_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lookup path with write-to-read bypass
  // ---------------------------------------------------------------------------
  entry_t rd_entry;
  logic   rd_hit;

  // A same-index write in this cycle is forwarded so fetch never sees stale data.
  assign rd_entry = (wr_en && (ex_idx == if_idx)) ? wr_entry_d : table_q[if_idx];
  assign rd_hit   = !rst && rd_entry.valid && (rd_entry.tag == if_tag);

  assign pred_hit    = rd_hit;
  assign pred_state  = rd_hit ? rd_entry.ctr : NTS;
  assign pred_taken  = rd_hit && pred_state[1];
  assign pred_target = pred_taken ? rd_entry.target : (if_pc + PC_W'(4));

endmodule

// File: tb/tb_branch_predict_table.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_table
// Self-checking bench for branch_predict_table (INDEX_W=6, PC_W=32).
// Directed scenarios use hand-derived constants; the random phase compares
// against a behavioural table model kept in plain arrays.
// -----------------------------------------------------------------------------
module tb_branch_predict_table;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_state;
  logic        ex_valid;
  logic        ex_is_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic [1:0]  ex_state_old;

  int checks   = 0;
  int failures = 0;

  logic [35:0] got;
  logic [35:0] exp;

  branch_predict_table #(.INDEX_W(6), .PC_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_pc        (if_pc),
    .pred_hit     (pred_hit),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .pred_state   (pred_state),
    .ex_valid     (ex_valid),
    .ex_is_branch (ex_is_branch),
    .ex_pc        (ex_pc),
    .ex_taken     (ex_taken),
    .ex_target    (ex_target),
    .ex_state_old (ex_state_old)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: 64 entries, index = pc[7:2], tag = pc[31:8]
  // ---------------------------------------------------------------------------
  bit        m_valid [64];
  bit [23:0] m_tag   [64];
  int        m_ctr   [64];
  bit [31:0] m_tgt   [64];

  // Counter transitions from the specification's table, as lookup arrays.
  function automatic int next_ctr(input int s, input bit x);
    int on_taken [4];
    int on_not   [4];
    on_taken = '{1, 3, 3, 3};
    on_not   = '{0, 0, 0, 2};
    return x ? on_taken[s] : on_not[s];
  endfunction

  // Expected {hit, taken, state, target} for a lookup in the current cycle,
  // including the effect of a same-cycle update to the same entry.
  function automatic logic [35:0] exp_lookup(input logic [31:0] pc);
    int        i;
    bit        v, h;
    bit [23:0] tg;
    int        c;
    bit [31:0] t;
    bit [1:0]  st;
    i  = int'(pc[7:2]);
    v  = m_valid[i];
    tg = m_tag[i];
    c  = m_ctr[i];
    t  = m_tgt[i];
    if (!rst && ex_valid && ex_is_branch && int'(ex_pc[7:2]) == i) begin
      h = m_valid[i] && (m_tag[i] == ex_pc[31:8]);
      if (h || ex_taken) begin
        v  = 1'b1;
        tg = ex_pc[31:8];
        c  = next_ctr(int'(ex_state_old), ex_taken);
        if (ex_taken) t = ex_target;
      end
    end
    if (rst || !v || tg != pc[31:8]) return {1'b0, 1'b0, 2'b00, pc + 32'd4};
    st = 2'(c);
    if (st[1]) return {1'b1, 1'b1, st, t};
    return {1'b1, 1'b0, st, pc + 32'd4};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] <= 1'b0;
        m_ctr[i]   <= 0;
        m_tgt[i]   <= '0;
      end
    end else if (ex_valid && ex_is_branch) begin
      int i;
      i = int'(ex_pc[7:2]);
      if ((m_valid[i] && m_tag[i] == ex_pc[31:8]) || ex_taken) begin
        m_valid[i] <= 1'b1;
        m_tag[i]   <= ex_pc[31:8];
        m_ctr[i]   <= next_ctr(int'(ex_state_old), ex_taken);
        if (ex_taken) m_tgt[i] <= ex_target;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic [1:0] so);
    ex_valid     = 1'b1;
    ex_is_branch = 1'b1;
    ex_pc        = pc;
    ex_taken     = tk;
    ex_target    = tgt;
    ex_state_old = so;
  endtask

  task automatic clr_ex();
    ex_valid     = 1'b0;
    ex_is_branch = 1'b0;
    ex_pc        = '0;
    ex_taken     = 1'b0;
    ex_target    = '0;
    ex_state_old = 2'b00;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [23:0] tags [4];
    int          idx;
    tags = '{24'h000010, 24'h000011, 24'hFFFFFF, 24'h0000AB};
    idx  = $urandom_range(0, 4);
    if (idx == 4) idx = 63;
    return {tags[$urandom_range(0, 3)], 6'(idx), 2'b00};
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    clr_ex();
    if_pc = 32'h0000_1000;
    step();
    step();
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b0, 1'b0, 2'b00, 32'h0000_1004};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_forced got=%h exp=%h", got, exp);
    end
    if_pc = 32'hFFFF_FFFC;
    #1;
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b0, 1'b0, 2'b00, 32'h0000_0000};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset_pc_wrap got=%h exp=%h", got, exp);
    end
    step();
    rst   = 1'b0;
    if_pc = 32'h0000_1000;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b0, 1'b0, 2'b00, 32'h0000_1004};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL after_reset_miss got=%h exp=%h", got, exp);
    end
    step();
  endtask

  task automatic test_train();
    if_pc = 32'h0000_1004;
    set_ex(32'h0000_1000, 1'b1, 32'h0000_2000, 2'b00);
    step();
    clr_ex();
    if_pc = 32'h0000_1000;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b1, 1'b0, 2'b01, 32'h0000_1004};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL train_alloc got=%h exp=%h", got, exp);
    end
    step();
    if_pc = 32'h0000_1004;
    set_ex(32'h0000_1000, 1'b1, 32'h0000_2000, 2'b01);
    step();
    clr_ex();
    if_pc = 32'h0000_1000;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b1, 1'b1, 2'b11, 32'h0000_2000};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL train_ntw_to_ts got=%h exp=%h", got, exp);
    end
    step();
  endtask

  task automatic test_saturation();
    if_pc = 32'h0000_1004;
    set_ex(32'h0000_1000, 1'b1, 32'h0000_2000, 2'b11);
    step();
    clr_ex();
    if_pc = 32'h0000_1000;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b1, 1'b1, 2'b11, 32'h0000_2000};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL sat_ts_taken got=%h exp=%h", got, exp);
    end
    step();
    if_pc = 32'h0000_1004;
    set_ex(32'h0000_1000, 1'b0, 32'h0000_9999, 2'b11);
    step();
    clr_ex();
    if_pc = 32'h0000_1000;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b1, 1'b1, 2'b10, 32'h0000_2000};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL sat_ts_not_taken got=%h exp=%h", got, exp);
    end
    step();
    if_pc = 32'h0000_1004;
    set_ex(32'h0000_1000, 1'b0, 32'h0000_9999, 2'b10);
    step();
    clr_ex();
    if_pc = 32'h0000_1000;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b1, 1'b0, 2'b00, 32'h0000_1004};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL sat_tw_not_taken got=%h exp=%h", got, exp);
    end
    step();
    // Not taken at NTS stays at NTS (lower saturation), entry still valid.
    if_pc = 32'h0000_1004;
    set_ex(32'h0000_1000, 1'b0, 32'h0000_9999, 2'b00);
    step();
    clr_ex();
    if_pc = 32'h0000_1000;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b1, 1'b0, 2'b00, 32'h0000_1004};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL sat_nts_not_taken got=%h exp=%h", got, exp);
    end
    step();
  endtask

  task automatic test_alias();
    if_pc = 32'h0000_1004;
    set_ex(32'h0000_1100, 1'b1, 32'h0000_5000, 2'b00);
    step();
    clr_ex();
    if_pc = 32'h0000_1000;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b0, 1'b0, 2'b00, 32'h0000_1004};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL alias_evicted got=%h exp=%h", got, exp);
    end
    if_pc = 32'h0000_1100;
    #1;
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b1, 1'b0, 2'b01, 32'h0000_1104};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL alias_new_owner got=%h exp=%h", got, exp);
    end
    step();
    if_pc = 32'h0000_1004;
    set_ex(32'h0000_1000, 1'b0, 32'h0000_6000, 2'b00);
    step();
    clr_ex();
    if_pc = 32'h0000_1100;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b1, 1'b0, 2'b01, 32'h0000_1104};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL alias_nt_miss_kept got=%h exp=%h", got, exp);
    end
    if_pc = 32'h0000_1000;
    #1;
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b0, 1'b0, 2'b00, 32'h0000_1004};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL alias_nt_miss_no_alloc got=%h exp=%h", got, exp);
    end
    step();
  endtask

  task automatic test_bypass();
    if_pc = 32'h0000_1004;
    set_ex(32'h0000_1000, 1'b1, 32'h0000_2000, 2'b00);
    step();
    // Same-cycle hit update and lookup.
    set_ex(32'h0000_1000, 1'b1, 32'h0000_2000, 2'b01);
    if_pc = 32'h0000_1000;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b1, 1'b1, 2'b11, 32'h0000_2000};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL bypass_hit_update got=%h exp=%h", got, exp);
    end
    step();
    // Same-cycle allocate over an aliasing entry, with a new target.
    set_ex(32'h0000_1100, 1'b1, 32'h0000_7000, 2'b10);
    if_pc = 32'h0000_1100;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b1, 1'b1, 2'b11, 32'h0000_7000};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL bypass_allocate got=%h exp=%h", got, exp);
    end
    step();
    clr_ex();
  endtask

  task automatic test_reset_midstream();
    for (int k = 0; k < 4; k++) begin
      set_ex(32'h0000_1000 + 32'(4 * k), 1'b1, 32'h0000_3000 + 32'(16 * k), 2'b11);
      if_pc = 32'h0000_2000;
      step();
    end
    clr_ex();
    if_pc = 32'h0000_100C;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b1, 1'b1, 2'b11, 32'h0000_3030};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL midrst_filled got=%h exp=%h", got, exp);
    end
    step();
    rst   = 1'b1;
    set_ex(32'h0000_1010, 1'b1, 32'h0000_4000, 2'b11);
    if_pc = 32'h0000_1004;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b0, 1'b0, 2'b00, 32'h0000_1008};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL midrst_forced got=%h exp=%h", got, exp);
    end
    step();
    rst = 1'b0;
    clr_ex();
    for (int k = 0; k < 5; k++) begin
      if_pc = 32'h0000_1000 + 32'(4 * k);
      #1;
      got = {pred_hit, pred_taken, pred_state, pred_target};
      exp = {1'b0, 1'b0, 2'b00, 32'h0000_1004 + 32'(4 * k)};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL midrst_miss_%0d got=%h exp=%h", k, got, exp);
      end
    end
    // In-flight state after reset: not-taken miss writes nothing.
    set_ex(32'h0000_1000, 1'b0, 32'h0000_3000, 2'b11);
    if_pc = 32'h0000_1004;
    step();
    clr_ex();
    if_pc = 32'h0000_1000;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b0, 1'b0, 2'b00, 32'h0000_1004};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL inflight_nt_miss got=%h exp=%h", got, exp);
    end
    step();
    // In-flight taken with stale TW: allocates with next-state TS.
    set_ex(32'h0000_1000, 1'b1, 32'h0000_3300, 2'b10);
    if_pc = 32'h0000_1004;
    step();
    clr_ex();
    if_pc = 32'h0000_1000;
    @(negedge clk);
    got = {pred_hit, pred_taken, pred_state, pred_target};
    exp = {1'b1, 1'b1, 2'b11, 32'h0000_3300};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL inflight_taken_alloc got=%h exp=%h", got, exp);
    end
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      ex_valid     = ($urandom_range(0, 3) != 0);
      ex_is_branch = ($urandom_range(0, 3) != 0);
      ex_pc        = rand_pc();
      ex_taken     = 1'($urandom_range(0, 1));
      ex_target    = $urandom();
      ex_state_old = 2'($urandom_range(0, 3));
      if_pc        = ($urandom_range(0, 3) == 0) ? ex_pc : rand_pc();
      @(negedge clk);
      got = {pred_hit, pred_taken, pred_state, pred_target};
      exp = exp_lookup(if_pc);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random_%0d pc=%h got=%h exp=%h", n, if_pc, got, exp);
      end
      step();
    end
    rst = 1'b0;
    clr_ex();
  endtask

  initial begin
    rst = 1'b1;
    if_pc = '0;
    clr_ex();
    test_reset();
    test_train();
    test_saturation();
    test_alias();
    test_bypass();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
